reset_stage_sequencer: RTL and testbench

Synthesizable, parametrised generator of the staged start/reset sequence and interrupt pulses that the accumulator processor top level needs after power-up. It drives STAGES sequential active-high reset pulses (stage 0 = global start, stage 1 = second-stage reset, and so on) with programmable delay, width and spacing. Once the sequence completes it injects bounded-width interrupt pulses on request. It sits between board reset and the processor top, replacing hand-timed stimulus.

---
 rtl/reset_stage_sequencer_pkg.sv | 30 +++
 rtl/reset_stage_sequencer_if.sv | 24 ++
 rtl/reset_stage_sequencer_irq_pulse_gen.sv | 73 +++++++
 rtl/reset_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_reset_stage_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_stage_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        PULSE,
        GAP,
        RUN
    } seq_state_t;

    // Width of every cycle down-counter; all timing parameters fit in 8 bits.
    localparam int CNT_W = 8;

    // Width of the stage index; up to eight stages.
    localparam int IDX_W = 3;

    // True when every timing parameter lies inside its supported range.
    function automatic bit params_ok(input int stages, input int init_delay,
                                     input int pulse_cycles, input int gap_cycles,
                                     input int irq_cycles);
        return (stages >= 1) && (stages <= 8) &&
               (init_delay >= 0) && (init_delay <= 255) &&
               (pulse_cycles >= 1) && (pulse_cycles <= 255) &&
               (gap_cycles >= 0) && (gap_cycles <= 255) &&
               (irq_cycles >= 1) && (irq_cycles <= 255);
    endfunction

endpackage

// File: rtl/reset_stage_sequencer_if.sv
// Control/status bundle between the board-side controller and the sequencer.
interface reset_stage_sequencer_if #(
    parameter int STAGES = 2
) ();
    logic              start;
    logic              irq_req;
    logic [STAGES-1:0] stage_rst;
    logic              busy;
    logic              done;
    logic              interrupt;
    logic              irq_dropped;

    // Controller side: issues start and interrupt requests, watches status.
    modport master (
        output start, irq_req,
        input  stage_rst, busy, done, interrupt, irq_dropped
    );

    // Sequencer side.
    modport slave (
        input  start, irq_req,
        output stage_rst, busy, done, interrupt, irq_dropped
    );
endinterface

// File: rtl/reset_stage_sequencer_irq_pulse_gen.sv
// Interrupt pulse generator: one-deep pending slot, fixed-width pulses and a
// sticky overflow flag. Pulses are only launched while enable is high; abort
// kills a pulse in flight and turns it back into a pending request.
module irq_pulse_gen
    import reset_seq_pkg::*;
#(
    parameter int IRQ_CYCLES = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic abort,
    input  logic irq_req,
    output logic interrupt,
    output logic irq_dropped
);
    localparam logic [CNT_W-1:0] IRQ_LOAD = CNT_W'(IRQ_CYCLES > 0 ? IRQ_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_reg;
    logic             pending_reg;
    logic             interrupt_reg;
    logic             dropped_reg;
    logic             collide;

    // Two or more of {pending, aborted pulse, new request} compete for one slot.
    assign collide = (pending_reg & interrupt_reg) | (pending_reg & irq_req) |
                     (interrupt_reg & irq_req);

    // Pulse launch, width count and pending/overflow bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg       <= '0;
            pending_reg   <= 1'b0;
            interrupt_reg <= 1'b0;
            dropped_reg   <= 1'b0;
        end else if (abort) begin
            interrupt_reg <= 1'b0;
            cnt_reg       <= '0;
            pending_reg   <= pending_reg | interrupt_reg | irq_req;
            if (collide) begin
                dropped_reg <= 1'b1;
            end
        end else if (!enable) begin
            if (irq_req) begin
                pending_reg <= 1'b1;
                if (pending_reg) begin
                    dropped_reg <= 1'b1;
                end
            end
        end else if (interrupt_reg) begin
            if (cnt_reg == '0) begin
                interrupt_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (irq_req) begin
                pending_reg <= 1'b1;
                if (pending_reg) begin
                    dropped_reg <= 1'b1;
                end
            end
        end else if (pending_reg || irq_req) begin
            // Pending goes first; a request arriving now takes the freed slot.
            interrupt_reg <= 1'b1;
            cnt_reg       <= IRQ_LOAD;
            pending_reg   <= pending_reg & irq_req;
        end
    end

    assign interrupt   = interrupt_reg;
    assign irq_dropped = dropped_reg;

endmodule

// File: rtl/reset_stage_sequencer.sv
// Staged power-up reset sequencer: delay, then STAGES one-hot reset pulses
// with programmable width and spacing, then RUN with interrupt injection.
module reset_stage_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES       = 2,
    parameter int INIT_DELAY   = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 2,
    parameter int IRQ_CYCLES   = 1
) (
    input  logic clk,
    input  logic resetn,
    reset_stage_sequencer_if.slave bus
);
    // An out-of-range configuration never leaves IDLE.
    localparam bit CFG_OK = params_ok(STAGES, INIT_DELAY, PULSE_CYCLES, GAP_CYCLES, IRQ_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(STAGES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(INIT_DELAY > 0 ? INIT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES > 0 ? PULSE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    seq_state_t        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [STAGES-1:0] stage_rst_reg;
    logic              busy_reg;
    logic              done_reg;

    logic restart;
    logic run_entry;
    logic irq_enable;
    logic interrupt_w;
    logic irq_dropped_w;

    function automatic logic [STAGES-1:0] stage_bit(input logic [IDX_W-1:0] i);
        return STAGES'(1) << i;
    endfunction

    // A start seen in RUN restarts the sequence and aborts any interrupt pulse.
    assign restart   = (state_reg == RUN) && bus.start && CFG_OK;
    // Last cycle of the final stage pulse: done rises on the coming edge.
    assign run_entry = (state_reg == PULSE) && (cnt_reg == '0) && (idx_reg == LAST_IDX);
    // Interrupts may launch on the same edge done rises, so enable looks ahead.
    assign irq_enable = ((state_reg == RUN) && !restart) || run_entry;

    // Sequencer FSM with registered stage, busy and done outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            stage_rst_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE, RUN: begin
                    if (bus.start && CFG_OK) begin
                        idx_reg  <= '0;
                        busy_reg <= 1'b1;
                        done_reg <= 1'b0;
                        if (INIT_DELAY == 0) begin
                            state_reg     <= PULSE;
                            cnt_reg       <= PULSE_LOAD;
                            stage_rst_reg <= stage_bit('0);
                        end else begin
                            state_reg <= DELAY;
                            cnt_reg   <= DELAY_LOAD;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= PULSE;
                        cnt_reg       <= PULSE_LOAD;
                        stage_rst_reg <= stage_bit(idx_reg);
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else if (idx_reg == LAST_IDX) begin
                        state_reg     <= RUN;
                        stage_rst_reg <= '0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        idx_reg       <= idx_reg + IDX_W'(1);
                        cnt_reg       <= PULSE_LOAD;
                        stage_rst_reg <= stage_bit(idx_reg + IDX_W'(1));
                    end else begin
                        state_reg     <= GAP;
                        cnt_reg       <= GAP_LOAD;
                        stage_rst_reg <= '0;
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= PULSE;
                        idx_reg       <= idx_reg + IDX_W'(1);
                        cnt_reg       <= PULSE_LOAD;
                        stage_rst_reg <= stage_bit(idx_reg + IDX_W'(1));
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    irq_pulse_gen #(
        .IRQ_CYCLES(IRQ_CYCLES)
    ) u_irq (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (irq_enable),
        .abort      (restart),
        .irq_req    (bus.irq_req),
        .interrupt  (interrupt_w),
        .irq_dropped(irq_dropped_w)
    );

    assign bus.stage_rst   = stage_rst_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.interrupt   = interrupt_w;
    assign bus.irq_dropped = irq_dropped_w;

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Bench for reset_stage_sequencer: two configurations driven by the same
// stimulus, each checked every cycle against a timing-formula reference.
module tb_reset_stage_sequencer;
    localparam int NU = 2;

    // Unit 0: default configuration. Unit 1: no delay, no gap, 3 stages, wide IRQ.
    int stg [NU] = '{2, 3};
    int dly [NU] = '{2, 0};
    int pul [NU] = '{1, 2};
    int gp  [NU] = '{2, 0};
    int irqw[NU] = '{1, 3};

    logic clk     = 1'b0;
    logic resetn  = 1'b0;
    logic start   = 1'b0;
    logic irq_req = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reset_stage_sequencer_if #(.STAGES(2)) bus_a ();
    reset_stage_sequencer_if #(.STAGES(3)) bus_b ();

    assign bus_a.start   = start;
    assign bus_a.irq_req = irq_req;
    assign bus_b.start   = start;
    assign bus_b.irq_req = irq_req;

    reset_stage_sequencer #(
        .STAGES(2), .INIT_DELAY(2), .PULSE_CYCLES(1), .GAP_CYCLES(2), .IRQ_CYCLES(1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a)
    );

    reset_stage_sequencer #(
        .STAGES(3), .INIT_DELAY(0), .PULSE_CYCLES(2), .GAP_CYCLES(0), .IRQ_CYCLES(3)
    ) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b)
    );

    // ---------------- reference model ----------------
    // t = cycles elapsed since the accepted start edge (0 = first busy cycle).
    bit started[NU];
    int t      [NU];
    bit pend   [NU];
    bit drop   [NU];
    int irq_rem[NU];

    function automatic int busy_len(input int u);
        return dly[u] + stg[u] * pul[u] + (stg[u] - 1) * gp[u];
    endfunction

    function automatic logic [11:0] expect_vec(input int u);
        logic [7:0] st;
        bit b, d;
        st = '0;
        b  = started[u] && (t[u] < busy_len(u));
        d  = started[u] && (t[u] >= busy_len(u));
        if (b) begin
            for (int i = 0; i < 8; i++) begin
                if (i < stg[u]) begin
                    int s;
                    s = dly[u] + i * (pul[u] + gp[u]);
                    if (t[u] >= s && t[u] < s + pul[u]) st[i] = 1'b1;
                end
            end
        end
        return {st, b, d, irq_rem[u] > 0, drop[u]};
    endfunction

    function automatic logic [11:0] obs_vec(input int u);
        if (u == 0)
            return {6'b0, bus_a.stage_rst, bus_a.busy, bus_a.done, bus_a.interrupt, bus_a.irq_dropped};
        return {5'b0, bus_b.stage_rst, bus_b.busy, bus_b.done, bus_b.interrupt, bus_b.irq_dropped};
    endfunction

    task automatic model_step();
        if (!resetn) begin
            for (int u = 0; u < NU; u++) begin
                started[u] = 0; t[u] = 0; pend[u] = 0; drop[u] = 0; irq_rem[u] = 0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                int bl;
                bit in_run, accept, active, en;
                int n;
                bl     = busy_len(u);
                in_run = started[u] && (t[u] >= bl);
                accept = start && (!started[u] || in_run);
                active = irq_rem[u] > 0;
                if (accept) begin
                    started[u] = 1; t[u] = 0;
                end else if (started[u] && t[u] < bl) begin
                    t[u]++;
                end
                en = started[u] && (t[u] >= bl);
                if (accept && in_run) begin
                    n = int'(pend[u]) + int'(active) + int'(irq_req);
                    if (n >= 2) drop[u] = 1;
                    pend[u]    = (n >= 1);
                    irq_rem[u] = 0;
                end else if (!en || active) begin
                    if (active) irq_rem[u]--;
                    if (irq_req) begin
                        if (pend[u]) drop[u] = 1;
                        pend[u] = 1;
                    end
                end else if (pend[u]) begin
                    irq_rem[u] = irqw[u];
                    pend[u]    = irq_req;
                end else if (irq_req) begin
                    irq_rem[u] = irqw[u];
                end
            end
        end
    endtask

    always @(posedge clk or negedge resetn) model_step();

    // Reset, start, and wait until both units sit in RUN (no checking here).
    task automatic run_to_done();
        @(negedge clk); resetn = 1'b0; start = 1'b0; irq_req = 1'b0;
        @(negedge clk); resetn = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; irq_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL reset unit%0d t=%0t got %b want %b", u, $time, obs_vec(u), expect_vec(u));
                end
            end
            vectors++;
            if (obs_vec(0) !== 12'b0) begin
                miscompares++;
                $display("FAIL reset_zero t=%0t got %b want 0", $time, obs_vec(0));
            end
        end
        resetn = 1'b1;
        $display("test_reset: %0d vectors so far", vectors);
    endtask

    task automatic test_sequence();
        logic [2:0] b_seq[6];
        logic [2:0] b_want[6];
        int busy_a, busy_b;
        b_want = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
        busy_a = 0; busy_b = 0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL sequence unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
            if (bus_a.busy) busy_a++;
            if (bus_b.busy) busy_b++;
            if (i < 6) b_seq[i] = bus_b.stage_rst;
            if (i == 2 || i == 5) begin
                vectors++;
                if (bus_a.stage_rst !== (i == 2 ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL seq_a_stage cycle%0d got %b", i, bus_a.stage_rst);
                end
            end
            if (i == 6) begin
                vectors++;
                if (bus_a.done !== 1'b1 || bus_b.done !== 1'b1 || bus_a.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL seq_done_rise got done_a=%b done_b=%b busy_a=%b want 1 1 0",
                             bus_a.done, bus_b.done, bus_a.busy);
                end
            end
        end
        vectors++;
        if (busy_a != 6 || busy_b != 6) begin
            miscompares++;
            $display("FAIL seq_busy_len got %0d/%0d want 6/6", busy_a, busy_b);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (b_seq[i] !== b_want[i]) begin
                miscompares++;
                $display("FAIL seq_b_stage cycle%0d got %b want %b", i, b_seq[i], b_want[i]);
            end
        end
        $display("test_sequence: busy_a=%0d busy_b=%0d", busy_a, busy_b);
    endtask

    task automatic test_pending_irq();
        int first_a, first_b, cnt_a, cnt_b;
        first_a = -1; first_b = -1; cnt_a = 0; cnt_b = 0;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL pending unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
            if (bus_a.interrupt) begin cnt_a++; if (first_a < 0) first_a = i; end
            if (bus_b.interrupt) begin cnt_b++; if (first_b < 0) first_b = i; end
            irq_req = (i == 1 || i == 3);
        end
        vectors++;
        if (first_a != 6 || first_b != 6 || cnt_a != 1 || cnt_b != 3) begin
            miscompares++;
            $display("FAIL pending_pulse got first=%0d/%0d len=%0d/%0d want 6/6 1/3",
                     first_a, first_b, cnt_a, cnt_b);
        end
        vectors++;
        if (bus_a.irq_dropped !== 1'b1 || bus_b.irq_dropped !== 1'b1) begin
            miscompares++;
            $display("FAIL pending_dropped got %b/%b want 1/1", bus_a.irq_dropped, bus_b.irq_dropped);
        end
        $display("test_pending_irq: first=%0d/%0d", first_a, first_b);
    endtask

    task automatic test_irq_held();
        run_to_done();
        irq_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL held unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
            if (i < 12) begin
                vectors++;
                if (bus_b.interrupt !== ((i % 4) != 3) || bus_a.interrupt !== ((i % 2) == 0)) begin
                    miscompares++;
                    $display("FAIL held_pattern cycle%0d got a=%b b=%b want a=%b b=%b", i,
                             bus_a.interrupt, bus_b.interrupt, (i % 2) == 0, (i % 4) != 3);
                end
            end
            if (i == 11) irq_req = 1'b0;
        end
        $display("test_irq_held: done");
    endtask

    task automatic test_restart_abort();
        run_to_done();
        irq_req = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL restart unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
            if (i == 1 || i == 6 || i == 7) begin
                vectors++;
                if (bus_b.interrupt !== (i == 7) || bus_b.done !== (i == 7) || bus_b.busy !== (i != 7)) begin
                    miscompares++;
                    $display("FAIL restart_b cycle%0d got int=%b done=%b busy=%b", i,
                             bus_b.interrupt, bus_b.done, bus_b.busy);
                end
            end
            irq_req = 1'b0;
            start   = (i == 0);
        end
        $display("test_restart_abort: done");
    endtask

    task automatic test_reset_mid_pulse();
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus_a.stage_rst !== 2'b01 || bus_b.stage_rst !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_pulse_pre got %b/%b want 01/010", bus_a.stage_rst, bus_b.stage_rst);
        end
        #2 resetn = 1'b0;
        #1;
        for (int u = 0; u < NU; u++) begin
            vectors++;
            if (obs_vec(u) !== 12'b0) begin
                miscompares++;
                $display("FAIL mid_pulse_async unit%0d got %b want 0", u, obs_vec(u));
            end
        end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u) || obs_vec(u) !== 12'b0) begin
                    miscompares++;
                    $display("FAIL mid_pulse_idle unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
        end
        $display("test_reset_mid_pulse: done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                vectors++;
                if (obs_vec(u) !== expect_vec(u)) begin
                    miscompares++;
                    $display("FAIL random unit%0d cycle%0d got %b want %b", u, i, obs_vec(u), expect_vec(u));
                end
            end
            start   = ($urandom_range(0, 11) == 0);
            irq_req = ($urandom_range(0, 3) == 0);
            resetn  = ($urandom_range(0, 249) != 0);
        end
        resetn = 1'b1;
        $display("test_random: done");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_pending_irq();
        test_irq_held();
        test_restart_abort();
        test_reset_mid_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
